pipe_credit_sink: RTL and testbench

- Consumer-side end of a fixed-latency `register_pipe` datapath in the CGRA.
- Issues credits to the upstream issuer and tracks in-flight tokens with an internal valid shadow of the pipe's latency.
- Captures the pipe output into a FIFO and re-presents it as a valid/ready stream, so a downstream stall never requires stalling the non-stallable pipe.
- Guarantees no data loss: issue is allowed only when FIFO occupancy plus in-flight tokens is below DEPTH.

---
 rtl/pipe_credit_sink.sv | 105 ++++++++++
 tb/tb_pipe_credit_sink.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_credit_sink.sv
// Consumer end of a fixed-latency, non-stallable pipe: hands out credits, tracks
// in-flight tokens with a valid shadow, and re-buffers landed data as a stream.
module pipe_credit_sink #(
  parameter int DATA_WIDTH = 8,
  parameter int LATENCY    = 6,
  parameter int DEPTH      = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          pipe_dout,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [DATA_WIDTH-1:0]          m_data,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic [$clog2(LATENCY+1)-1:0]   inflight,
  output logic                           ovf
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LATENCY + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = ((LW > IW) ? LW : IW) + 1;

  // Handshakes: a token issues on in_valid & in_ready and a stream beat transfers
  // on m_valid & m_ready, both at the rising edge; in_ready never looks at m_ready.
  logic                  issue;
  logic                  land;
  logic                  pop;
  logic                  full;
  logic                  do_write;
  logic                  drop;
  logic [SW-1:0]         occupancy;
  logic [LATENCY-1:0]    shadow;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign occupancy = SW'(level) + SW'(inflight);
  assign in_ready  = rst & (occupancy < SW'(DEPTH));
  assign issue     = in_valid & in_ready;
  assign land      = shadow[LATENCY-1];
  assign m_valid   = (level != '0);
  assign pop       = m_valid & m_ready;
  assign full      = (level == LW'(DEPTH));
  // When full, a same-edge pop frees the slot the landing token writes into.
  assign do_write  = land & (~full | pop);
  assign drop      = land & full & ~pop;
  assign m_data    = m_valid ? mem[head] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= '0;
    end else begin
      shadow[0] <= issue;
      for (int i = 1; i < LATENCY; i++) begin
        shadow[i] <= shadow[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
    end else begin
      case ({issue, land})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= '0;
      head  <= '0;
      tail  <= '0;
      ovf   <= 1'b0;
    end else begin
      case ({do_write, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (do_write) begin
        tail <= (tail == PW'(DEPTH - 1)) ? '0 : tail + PW'(1);
      end
      if (pop) begin
        head <= (head == PW'(DEPTH - 1)) ? '0 : head + PW'(1);
      end
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[tail] <= pipe_dout;
    end
  end

endmodule

// File: tb/tb_pipe_credit_sink.sv
// Directed bench for pipe_credit_sink: external pipe model, queue-based reference
// model checked every cycle, plus literal expectations for the key scenarios.
module tb_pipe_credit_sink;

  localparam int DW  = 8;
  localparam int LAT = 6;
  localparam int DEP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] pipe_dout;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [$clog2(DEP+1)-1:0] level;
  logic [$clog2(LAT+1)-1:0] inflight;
  logic          ovf;

  int n_checks = 0;
  int n_errors = 0;

  pipe_credit_sink #(.DATA_WIDTH(DW), .LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pipe_dout(pipe_dout), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .level(level), .inflight(inflight), .ovf(ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  // external register_pipe: always enabled, never reset
  logic [DW-1:0] pipe [LAT];
  initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
  always @(posedge clk) begin
    pipe[0] <= din;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign pipe_dout = pipe[LAT-1];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // reference model: tokens carry their landing cycle and data; FIFO is a queue
  typedef struct {
    int          land_cyc;
    logic [DW-1:0] data;
  } tok_t;
  tok_t          pend_q[$];
  logic [DW-1:0] exp_q[$];
  bit            mdl_ovf = 1'b0;
  int            cyc = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q.delete();
      exp_q.delete();
      mdl_ovf = 1'b0;
    end else begin
      bit            iss;
      bit            pp;
      bit            lnd;
      logic [DW-1:0] ld;
      iss = in_valid && ((exp_q.size() + pend_q.size()) < DEP);
      pp  = m_ready && (exp_q.size() > 0);
      lnd = (pend_q.size() > 0) && (pend_q[0].land_cyc == cyc);
      ld  = '0;
      if (lnd) begin
        ld = pend_q[0].data;
        void'(pend_q.pop_front());
      end
      if (pp) void'(exp_q.pop_front());
      if (lnd) begin
        if (exp_q.size() < DEP) exp_q.push_back(ld);
        else mdl_ovf = 1'b1;
      end
      if (iss) pend_q.push_back('{cyc + LAT, din});
      cyc++;
    end
  end

  // scoreboard compare on the falling edge, plus stream capture
  bit            cap_en = 1'b0;
  logic [DW-1:0] got_q[$];
  int            first_pop = -1;
  int            last_pop = -1;

  always @(negedge clk) begin
    chk("in_ready", int'(in_ready),
        int'(rst && ((exp_q.size() + pend_q.size()) < DEP)));
    chk("m_valid", int'(m_valid), int'(exp_q.size() > 0));
    chk("level", int'(level), exp_q.size());
    chk("inflight", int'(inflight), pend_q.size());
    chk("ovf", int'(ovf), int'(mdl_ovf));
    if (exp_q.size() > 0) chk("m_data", int'(m_data), int'(exp_q[0]));
    if (cap_en && m_valid && m_ready) begin
      got_q.push_back(m_data);
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
  end

  initial begin
    int n_iss;
    int drops;

    // reset held with in_valid asserted
    rst = 1'b0;
    in_valid = 1'b1;
    step(3);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_inflight", int'(inflight), 0);
    chk("rst_m_data", int'(m_data), 0);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rel_in_ready", int'(in_ready), 1);
    step();

    // single token
    in_valid = 1'b1;
    din = 8'h01;
    step();
    in_valid = 1'b0;
    din = 8'hEE;
    for (int i = 0; i < LAT - 1; i++) begin
      chk("single_inflight", int'(inflight), 1);
      chk("single_no_valid", int'(m_valid), 0);
      step();
    end
    chk("single_inflight_last", int'(inflight), 1);
    step();
    chk("single_valid", int'(m_valid), 1);
    chk("single_data", int'(m_data), 8'h01);
    chk("single_landed", int'(inflight), 0);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("single_popped", int'(level), 0);

    // backpressure fill
    n_iss = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din = 8'(8'h10 + i);
      if (in_ready) n_iss++;
      step();
    end
    chk("fill_issues", n_iss, 8);
    chk("fill_in_ready", int'(in_ready), 0);
    chk("fill_level", int'(level), 8);
    chk("fill_inflight", int'(inflight), 0);
    chk("fill_ovf", int'(ovf), 0);
    chk("fill_head", int'(m_data), 8'h10);

    // credit return: one pop buys exactly one more issue
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("credit_head", int'(m_data), 8'h11);
    chk("credit_in_ready", int'(in_ready), 1);
    din = 8'h55;
    step();
    chk("credit_inflight", int'(inflight), 1);
    n_iss = 0;
    for (int i = 0; i < 10; i++) begin
      din = 8'hCC;
      if (in_ready) n_iss++;
      step();
    end
    in_valid = 1'b0;
    chk("credit_extra", n_iss, 0);
    chk("credit_level", int'(level), 8);
    chk("credit_ovf", int'(ovf), 0);

    // drain
    m_ready = 1'b1;
    step(12);
    chk("drain_level", int'(level), 0);

    // streaming 0x00..0x63
    got_q.delete();
    cap_en = 1'b1;
    drops = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      din = 8'(i);
      if (!in_ready) drops++;
      step();
    end
    in_valid = 1'b0;
    step(LAT + 4);
    cap_en = 1'b0;
    chk("stream_ready_drops", drops, 0);
    chk("stream_count", got_q.size(), 100);
    if (got_q.size() == 100) begin
      for (int i = 0; i < 100; i++) chk("stream_order", int'(got_q[i]), i);
    end
    chk("stream_contig", last_pop - first_pop, 99);
    m_ready = 1'b0;

    // reset in mid-flight
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 8'(8'hA0 + i);
      step();
    end
    in_valid = 1'b0;
    step(2);
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("mid_rst_no_valid", int'(m_valid), 0);
      chk("mid_rst_level", int'(level), 0);
      chk("mid_rst_inflight", int'(inflight), 0);
      step();
    end
    chk("mid_rst_ovf", int'(ovf), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
